ft_wb_master: RTL
=================

// Module: ft_wb_master
// PURPOSE
//  Command executor directly downstream of the FT245 host interface. It consumes parsed
//  host packets (ping / write / read), runs Wishbone classic single cycles, and returns
//  response headers and read data through the host interface output handshake.
// PARAMETERS
//  ADDR_INC        1     wb_adr_o increment per word (word addressing)
//  TIMEOUT_CYCLES  1024  ack wait limit; used only with FT_WB_TIMEOUT_EN
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  master_ready    out  1   ready to accept an ih_ready pulse
//  ih_ready        in   1   1-cycle pulse: in_* valid
//  in_command      in   32  [3:0] 0=ping 1=write 2=read; other bits ignored
//  in_address      in   32  start address
//  in_data_count   in   28  words-1
//  in_data         in   32  write data word
//  oh_ready        in   1   host interface can take a response beat
//  oh_en           out  1   1-cycle pulse: out_* valid
//  out_status      out  32  {27'h0, err, ~cmd[3:0]}
//  out_address     out  32  latched start address (0 for ping)
//  out_data_count  out  28  words-1 (0 for ping/write ack)
//  out_data        out  32  read word (0 for ping/write ack)
//  wb_adr_o/wb_dat_o out 32; wb_dat_i in 32; wb_we_o, wb_stb_o, wb_cyc_o out 1;
//  wb_sel_o out 4; wb_ack_i in 1
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; master_ready=1; oh_en, wb_stb_o, wb_cyc_o,
//   wb_we_o = 0; all data/address outputs = 0; wb_sel_o = 4'hF; err=0. Mid-operation
//   reset aborts any bus cycle at once; no response is sent.
//  All outputs are registered. ih_ready is sampled only when master_ready=1; otherwise it is ignored.
//  IDLE (master_ready=1): on ih_ready latch cmd, addr, count, data; err<=0.
//   cmd 0 -> RESP; cmd 1 -> WR_BUS; cmd 2 -> RD_BUS; other -> stay IDLE, drop packet.
//  WR_BUS: assert cyc=stb=we=1, adr=addr, dat=data, and hold them until wb_ack_i.
//   In the cycle after ack, drop cyc/stb/we and set addr += ADDR_INC.
//   Then remaining==0 -> RESP; else remaining-1 -> WR_WAIT.
//  WR_WAIT (master_ready=1): on ih_ready latch in_data -> WR_BUS.
//  RD_BUS: cyc=stb=1, we=0 until ack; latch wb_dat_i into out_data -> RD_SEND.
//  RD_SEND: wait oh_ready=1, then pulse oh_en 1 cycle.
//   The first beat carries status/address/count; later beats carry only data changes.
//   After the pulse: remaining==0 -> IDLE; else remaining-1, addr += ADDR_INC, -> RD_BUS.
//  RESP: wait oh_ready=1, pulse oh_en 1 cycle with header only -> IDLE.
//   Ping status = 0x0F; write ack = 0x0E (| err<<4).
//  oh_en is never high on consecutive cycles. master_ready=0 in all states except IDLE/WR_WAIT.
//  Count 28'hFFFFFFF is legal. Address wraps at 2^32.
//  out_data_count echoes the latched count for reads.
//  ack arriving in the same cycle stb rises is accepted. wb_ack_i is ignored while cyc=0.
// CONFIGURATION
//  FT_WB_TIMEOUT_EN defined: an ack wait counter runs in WR_BUS/RD_BUS.
//   At TIMEOUT_CYCLES without ack: drop cyc/stb, set sticky err.
//   All remaining words of the packet then skip the bus: writes are still consumed via
//   WR_WAIT, reads return 32'h0. err is reported in status bit 4 of the next header sent.
//  Not defined: no counter; a missing ack hangs the block until reset; status bit 4 = 0.
// STRUCTURE
//  ft_host_defs.vh: CMD_PING/CMD_WRITE/CMD_READ, STATUS_ERR_BIT, state encodings.
//  One sub-module, wb_single_cycle: drives cyc/stb/we for one transfer and returns
//   done/rdata/timeout. It contains the timeout counter under FT_WB_TIMEOUT_EN.
// TESTING
//  1. ping (cmd 0) -> one oh_en, status 0x0F, address 0, count 0, no wb cycle.
//  2. write addr 0x100, count 2, data 11/22/33 with ack delays 0/3/1:
//     -> wb writes to 0x100/0x101/0x102, then one oh_en with status 0x0E.
//  3. read addr 0x20, count 3, slave returns addr^0xA5A5:
//     -> 4 oh_en pulses with matching data; oh_ready held low 5 cycles between beats
//     -> no dropped or duplicated beat.
//  4. ih_ready pulsed while master_ready=0 (during RD_BUS) -> ignored, no state change.
//  5. rst_n low mid write burst with stb high -> cyc/stb/oh_en low asynchronously;
//     IDLE, master_ready=1 after release.
//  6. FT_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack on read count 1:
//     -> stb drops after 16 cycles; 2 beats, data 0, status 0x1D.

Source files
------------

// File: rtl/ft_wb_master_pkg.sv
// ft_wb_master_pkg: shared definitions for the FT245 command executor.
//   CMD_*          host packet command codes (in_command[3:0])
//   STATUS_ERR_BIT bit of the response status word carrying the sticky bus error
//   state_t        executor FSM states
//   status_word()  builds the response status word {27'h0, err, ~cmd}
package ft_wb_master_pkg;

  localparam logic [3:0] CMD_PING  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_READ  = 4'd2;

  localparam int unsigned STATUS_ERR_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BUS,
    ST_WR_WAIT,
    ST_RD_BUS,
    ST_RD_SEND,
    ST_RESP
  } state_t;

  function automatic logic [31:0] status_word(input logic [3:0] cmd, input logic err);
    logic [31:0] s;
    s                 = '0;
    s[3:0]            = ~cmd;
    s[STATUS_ERR_BIT] = err;
    return s;
  endfunction

endpackage

// File: rtl/ft_wb_master_wb_single_cycle.sv
// wb_single_cycle: runs one Wishbone classic single cycle.
//   start/start_we  1-cycle request; cyc/stb/we rise on the following edge
//   ack/dat_i       slave acknowledge and read data
//   cyc/stb/we/sel  registered bus controls (sel fixed to all byte lanes)
//   done            ack seen while the cycle is open (combinational)
//   rdata           dat_i qualified by done, 0 otherwise
//   timeout         ack wait limit reached (only with FT_WB_TIMEOUT_EN defined)
// Macro FT_WB_TIMEOUT_EN enables the TIMEOUT_CYCLES ack wait counter; without it
// a missing ack keeps the cycle open indefinitely.
module wb_single_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        start_we,
  input  logic        ack,
  input  logic [31:0] dat_i,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata
);

`ifdef FT_WB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic [31:0] wait_cnt;

  assign sel     = '1;
  assign done    = cyc & ack;
  assign rdata   = done ? dat_i : '0;
  // wait_cnt counts completed ack-less cycles, so the cycle stays open for
  // exactly TIMEOUT_CYCLES clocks before being abandoned.
  assign timeout = TIMEOUT_EN && cyc && !ack && (wait_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 1'b0;
      stb      <= 1'b0;
      we       <= 1'b0;
      wait_cnt <= '0;
    end else if (start) begin
      cyc      <= 1'b1;
      stb      <= 1'b1;
      we       <= start_we;
      wait_cnt <= '0;
    end else if (done || timeout) begin
      cyc <= 1'b0;
      stb <= 1'b0;
      we  <= 1'b0;
    end else if (TIMEOUT_EN && cyc) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ft_wb_master.sv
// ft_wb_master: executes parsed FT245 host packets (ping / write / read) as
// Wishbone classic single cycles and returns response beats to the host side.
//   master_ready  high in IDLE/WR_WAIT: an ih_ready pulse will be taken
//   ih_ready      1-cycle pulse qualifying in_command/in_address/in_data_count/in_data
//   oh_ready      host side can take a response beat
//   oh_en         1-cycle pulse qualifying out_status/out_address/out_data_count/out_data
//   wb_*          Wishbone classic master port (sel always 4'hF)
// Parameters: ADDR_INC address step per word; TIMEOUT_CYCLES ack wait limit.
// Macro FT_WB_TIMEOUT_EN enables the ack timeout and sticky err (status bit 4).
module ft_wb_master
  import ft_wb_master_pkg::*;
#(
  parameter int unsigned ADDR_INC       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        master_ready,
  input  logic        ih_ready,
  input  logic [31:0] in_command,
  input  logic [31:0] in_address,
  input  logic [27:0] in_data_count,
  input  logic [31:0] in_data,
  input  logic        oh_ready,
  output logic        oh_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [27:0] out_data_count,
  output logic [31:0] out_data,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  state_t      state, next_state;
  logic [3:0]  cmd;
  logic [31:0] addr, start_addr, data;
  logic [27:0] count, remaining;
  logic        err;

  logic        start, start_we, done, timeout, cyc, bus_end;
  logic [31:0] rdata;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^in_command[31:4];

  wb_single_cycle #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .start_we (start_we),
    .ack      (wb_ack_i),
    .dat_i    (wb_dat_i),
    .cyc      (cyc),
    .stb      (wb_stb_o),
    .we       (wb_we_o),
    .sel      (wb_sel_o),
    .done     (done),
    .timeout  (timeout),
    .rdata    (rdata)
  );

  assign wb_cyc_o = cyc;
  assign wb_adr_o = addr;
  assign wb_dat_o = data;

  // After a timeout err is sticky and no further cycle is started, so a bus
  // state with cyc low completes immediately (skipped word).
  assign bus_end  = done | timeout | (err & ~cyc);
  assign start_we = (next_state == ST_WR_BUS);

  always_comb begin
    next_state = state;
    start      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ih_ready) begin
          case (in_command[3:0])
            CMD_PING:  next_state = ST_RESP;
            CMD_WRITE: begin next_state = ST_WR_BUS; start = 1'b1; end
            CMD_READ:  begin next_state = ST_RD_BUS; start = 1'b1; end
            default:   next_state = ST_IDLE;
          endcase
        end
      end
      ST_WR_BUS: begin
        if (bus_end) next_state = (remaining == '0) ? ST_RESP : ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (ih_ready) begin
          next_state = ST_WR_BUS;
          start      = ~err;
        end
      end
      ST_RD_BUS: begin
        if (bus_end) next_state = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (oh_ready) begin
          if (remaining == '0) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_RD_BUS;
            start      = ~err;
          end
        end
      end
      ST_RESP: begin
        if (oh_ready) next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      master_ready   <= 1'b1;
      oh_en          <= 1'b0;
      out_status     <= '0;
      out_address    <= '0;
      out_data_count <= '0;
      out_data       <= '0;
      cmd            <= '0;
      addr           <= '0;
      start_addr     <= '0;
      data           <= '0;
      count          <= '0;
      remaining      <= '0;
      err            <= 1'b0;
    end else begin
      state        <= next_state;
      master_ready <= (next_state == ST_IDLE) || (next_state == ST_WR_WAIT);
      oh_en        <= 1'b0;
      if (timeout) err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (ih_ready) begin
            cmd        <= in_command[3:0];
            addr       <= in_address;
            start_addr <= in_address;
            count      <= in_data_count;
            remaining  <= in_data_count;
            data       <= in_data;
            err        <= 1'b0;
          end
        end
        ST_WR_BUS: begin
          if (bus_end) begin
            addr <= addr + ADDR_INC;
            if (remaining != '0) remaining <= remaining - 28'd1;
          end
        end
        ST_WR_WAIT: begin
          if (ih_ready) data <= in_data;
        end
        ST_RD_BUS: begin
          if (bus_end) out_data <= rdata;
        end
        ST_RD_SEND: begin
          if (oh_ready) begin
            oh_en          <= 1'b1;
            out_status     <= status_word(cmd, err);
            out_address    <= start_addr;
            out_data_count <= count;
            if (remaining != '0) begin
              remaining <= remaining - 28'd1;
              addr      <= addr + ADDR_INC;
            end
          end
        end
        ST_RESP: begin
          if (oh_ready) begin
            oh_en          <= 1'b1;
            out_status     <= status_word(cmd, err);
            out_address    <= (cmd == CMD_PING) ? '0 : start_addr;
            out_data_count <= '0;
            out_data       <= '0;
          end
        end
      endcase
    end
  end

endmodule
